// File: rtl/apb_master.sv
// Command-driven APB master: queues host read/write commands in a small FIFO and
// runs each one through APB SETUP/ACCESS, returning one response beat per command.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  apb_write,
    output logic                  apb_sel,
    output logic                  apb_enable,
    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic [DATA_WIDTH-1:0] apb_wdata,
    input  logic                  apb_ready,
    input  logic [DATA_WIDTH-1:0] apb_rdata
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_r;
    logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_r;
    logic [PTR_W:0]       rd_ptr_r;
    logic [CNT_W-1:0]     tmo_cnt_r;
    logic                 empty_s;
    logic                 full_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ENTRY_W-1:0]   head_s;

    // FIFO status, handshake and busy; pointers carry an extra wrap bit
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        req_ready = !full_s && !rst;
        push_s    = req_valid && req_ready;
        pop_s     = (state_r == ST_IDLE) && !empty_s;
        busy      = !empty_s || (state_r != ST_IDLE);
        head_s    = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    end

    // Command storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= {req_write, req_addr, req_wdata};
        end
    end

    // FIFO pointers; reset flushes any queued commands
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W + 1){1'b0}};
            rd_ptr_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W + 1)'(1);
            end
        end
    end

    // APB sequencer with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= {CNT_W{1'b0}};
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= {ADDR_WIDTH{1'b0}};
            apb_wdata  <= {DATA_WIDTH{1'b0}};
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        {apb_write, apb_addr, apb_wdata} <= head_s;
                        apb_sel    <= 1'b1;
                        apb_enable <= 1'b0;
                        state_r    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_enable <= 1'b1;
                    tmo_cnt_r  <= {CNT_W{1'b0}};
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready on the expiry edge still counts as success
                    if (apb_ready) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= apb_write ? {DATA_WIDTH{1'b0}} : apb_rdata;
                        apb_sel    <= 1'b0;
                        apb_enable <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (tmo_cnt_r == TIMEOUT_VAL) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= {DATA_WIDTH{1'b0}};
                        apb_sel    <= 1'b0;
                        apb_enable <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    apb_sel    <= 1'b0;
                    apb_enable <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: two instances (default and short timeout) share stimulus and
// are checked every cycle against a transaction-level model plus directed literals.
module tb_apb_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       apb_ready = 1'b0;
    logic [7:0] apb_rdata = 8'h00;

    logic [1:0]      d_req_ready, d_resp_valid, d_resp_err, d_busy, d_write, d_sel, d_en;
    logic [1:0][7:0] d_rdata, d_addr, d_wdata;

    int cmp_count = 0;
    int fail_count = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    apb_master u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d_req_ready[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d_resp_valid[0]), .resp_rdata(d_rdata[0]), .resp_err(d_resp_err[0]),
        .busy(d_busy[0]), .apb_write(d_write[0]), .apb_sel(d_sel[0]), .apb_enable(d_en[0]),
        .apb_addr(d_addr[0]), .apb_wdata(d_wdata[0]),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    apb_master #(.TIMEOUT_CYCLES(15)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d_req_ready[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d_resp_valid[1]), .resp_rdata(d_rdata[1]), .resp_err(d_resp_err[1]),
        .busy(d_busy[1]), .apb_write(d_write[1]), .apb_sel(d_sel[1]), .apb_enable(d_en[1]),
        .apb_addr(d_addr[1]), .apb_wdata(d_wdata[1]),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    // Model: pending commands, and for the active command its ACCESS-cycle index
    logic [16:0] m_fifo [2][4];
    int          m_cnt [2];
    bit          m_active [2];
    int          m_age [2];
    logic        m_sel [2], m_en [2], m_w [2], m_rv [2], m_err [2];
    logic [7:0]  m_addr [2], m_wd [2], m_rd [2];

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s[u%0d]: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int  tmo;
        bit  can_push;
        tmo = (i == 0) ? 4095 : 15;
        if (rst) begin
            m_cnt[i] = 0; m_active[i] = 1'b0; m_age[i] = 0;
            m_sel[i] = 1'b0; m_en[i] = 1'b0; m_w[i] = 1'b0; m_rv[i] = 1'b0; m_err[i] = 1'b0;
            m_addr[i] = 8'h00; m_wd[i] = 8'h00; m_rd[i] = 8'h00;
        end else begin
            can_push = req_valid && (m_cnt[i] < 4);
            m_rv[i] = 1'b0;
            m_err[i] = 1'b0;
            if (!m_active[i]) begin
                if (m_cnt[i] > 0) begin
                    {m_w[i], m_addr[i], m_wd[i]} = m_fifo[i][0];
                    for (int j = 0; j < 3; j++) m_fifo[i][j] = m_fifo[i][j+1];
                    m_cnt[i]--;
                    m_active[i] = 1'b1; m_age[i] = 0; m_sel[i] = 1'b1; m_en[i] = 1'b0;
                end
            end else if (m_age[i] == 0) begin
                m_age[i] = 1; m_en[i] = 1'b1;
            end else if (apb_ready) begin
                m_rv[i] = 1'b1; m_rd[i] = m_w[i] ? 8'h00 : apb_rdata;
                m_active[i] = 1'b0; m_sel[i] = 1'b0; m_en[i] = 1'b0;
            end else if (m_age[i] == tmo + 1) begin
                m_rv[i] = 1'b1; m_err[i] = 1'b1; m_rd[i] = 8'h00;
                m_active[i] = 1'b0; m_sel[i] = 1'b0; m_en[i] = 1'b0;
            end else begin
                m_age[i]++;
            end
            if (can_push) begin
                m_fifo[i][m_cnt[i]] = {req_write, req_addr, req_wdata};
                m_cnt[i]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("req_ready", i, 32'(d_req_ready[i]), 32'(!rst && (m_cnt[i] < 4)));
                check("busy", i, 32'(d_busy[i]), 32'((m_cnt[i] > 0) || m_active[i]));
                check("apb_sel", i, 32'(d_sel[i]), 32'(m_sel[i]));
                check("apb_enable", i, 32'(d_en[i]), 32'(m_en[i]));
                check("apb_write", i, 32'(d_write[i]), 32'(m_w[i]));
                check("apb_addr", i, 32'(d_addr[i]), 32'(m_addr[i]));
                check("apb_wdata", i, 32'(d_wdata[i]), 32'(m_wd[i]));
                check("resp_valid", i, 32'(d_resp_valid[i]), 32'(m_rv[i]));
                check("resp_err", i, 32'(d_resp_err[i]), 32'(m_err[i]));
                check("resp_rdata", i, 32'(d_rdata[i]), 32'(m_rd[i]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0;
    endtask

    // Acts as the slave for u0: waits for ACCESS, stalls, then completes with rd
    task automatic serve(input int waits, input logic [7:0] rd, output int gap,
                         output logic [7:0] addr_seen);
        int guard;
        gap = 0;
        guard = 0;
        while (!d_en[0] && guard < 60) begin
            if (!d_sel[0]) gap++;
            tick;
            guard++;
        end
        check("serve_bound", 0, 32'(guard < 60), 32'd1);
        addr_seen = d_addr[0];
        repeat (waits) tick;
        apb_ready = 1'b1;
        apb_rdata = rd;
        tick;
        apb_ready = 1'b0;
    endtask

    initial begin
        int         acc, gap, n, g;
        logic [7:0] a;

        // Reset values
        tick; tick;
        chk_en = 1'b1;
        at_neg;
        check("rst_sel", 0, 32'(d_sel[0]), 32'd0);
        check("rst_busy", 0, 32'(d_busy[0]), 32'd0);
        check("rst_req_ready", 0, 32'(d_req_ready[0]), 32'd0);
        check("rst_rdata", 0, 32'(d_rdata[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("req_ready_after_rst", 0, 32'(d_req_ready[0]), 32'd1);
        tick;

        // Single write, 20 ACCESS cycles; bus read data must not leak into the response
        apb_rdata = 8'hA5;
        push(1'b1, 8'h41, 8'h05);
        tick;
        at_neg;
        check("setup_sel", 0, 32'(d_sel[0]), 32'd1);
        check("setup_enable", 0, 32'(d_en[0]), 32'd0);
        check("setup_addr", 0, 32'(d_addr[0]), 32'h41);
        check("setup_wdata", 0, 32'(d_wdata[0]), 32'h05);
        check("setup_write", 0, 32'(d_write[0]), 32'd1);
        tick;
        acc = 0;
        for (int k = 1; k <= 20; k++) begin
            at_neg;
            if (d_en[0]) acc++;
            if (k == 20) apb_ready = 1'b1;
            tick;
        end
        apb_ready = 1'b0;
        at_neg;
        check("wr_access_cycles", 0, 32'(acc), 32'd20);
        check("wr_resp_valid", 0, 32'(d_resp_valid[0]), 32'd1);
        check("wr_resp_err", 0, 32'(d_resp_err[0]), 32'd0);
        check("wr_resp_rdata", 0, 32'(d_rdata[0]), 32'd0);
        tick;

        // Single read
        push(1'b0, 8'h41, 8'h00);
        serve(2, 8'h05, gap, a);
        at_neg;
        check("rd_addr", 0, 32'(a), 32'h41);
        check("rd_resp_valid", 0, 32'(d_resp_valid[0]), 32'd1);
        check("rd_resp_rdata", 0, 32'(d_rdata[0]), 32'h05);
        check("rd_resp_err", 0, 32'(d_resp_err[0]), 32'd0);
        check("rd_resp_sel", 0, 32'(d_sel[0]), 32'd0);
        check("rd_resp_enable", 0, 32'(d_en[0]), 32'd0);
        tick;
        at_neg;
        check("rd_rdata_hold", 0, 32'(d_rdata[0]), 32'h05);
        tick;

        // Queued burst: one in flight plus four queued fills the FIFO
        for (int j = 0; j < 5; j++) begin
            req_valid = 1'b1;
            req_write = j[0];
            req_addr  = 8'h10 + 8'(j);
            req_wdata = 8'h20 + 8'(j);
            tick;
        end
        req_valid = 1'b0;
        at_neg;
        check("burst_full_ready", 0, 32'(d_req_ready[0]), 32'd0);
        check("burst_first_access", 0, 32'(d_en[0]), 32'd1);
        serve(1, 8'h70, gap, a);
        check("burst_order0", 0, 32'(a), 32'h10);
        at_neg;
        check("burst_resp_ready", 0, 32'(d_req_ready[0]), 32'd0);
        for (int j = 1; j < 5; j++) begin
            serve(1, 8'h70 + 8'(j), gap, a);
            check("burst_order", 0, 32'(a), 32'h10 + 32'(j));
            check("burst_idle_gap", 0, 32'(gap), 32'd1);
        end
        tick;

        // Timeout on u1 (15 cycles): error 16 cycles after ACCESS entry
        push(1'b0, 8'h80, 8'h00);
        push(1'b0, 8'hC1, 8'h00);
        g = 0;
        while (!d_en[1] && g < 10) begin tick; g++; end
        check("tmo_enter_bound", 1, 32'(g < 10), 32'd1);
        n = 0;
        while (!d_resp_valid[1] && n < 40) begin tick; n++; end
        at_neg;
        check("tmo_latency", 1, 32'(n), 32'd16);
        check("tmo_resp_err", 1, 32'(d_resp_err[1]), 32'd1);
        check("tmo_resp_rdata", 1, 32'(d_rdata[1]), 32'd0);
        check("tmo_u0_still_access", 0, 32'(d_en[0]), 32'd1);

        // Next command on u1: ready arrives exactly on the expiry edge
        g = 0;
        while (!d_en[1] && g < 10) begin tick; g++; end
        check("exp_enter_bound", 1, 32'(g < 10), 32'd1);
        repeat (15) tick;
        apb_rdata = 8'h3C;
        apb_ready = 1'b1;
        tick;
        apb_ready = 1'b0;
        at_neg;
        check("expiry_resp_valid", 1, 32'(d_resp_valid[1]), 32'd1);
        check("expiry_resp_err", 1, 32'(d_resp_err[1]), 32'd0);
        check("expiry_resp_rdata", 1, 32'(d_rdata[1]), 32'h3C);

        // Reset with one command in ACCESS on u0 and two queued
        push(1'b1, 8'h42, 8'h11);
        push(1'b0, 8'h43, 8'h00);
        tick;
        at_neg;
        check("pre_rst_enable", 0, 32'(d_en[0]), 32'd1);
        check("pre_rst_busy", 0, 32'(d_busy[0]), 32'd1);
        rst = 1'b1;
        tick;
        at_neg;
        check("mid_rst_sel", 0, 32'(d_sel[0]), 32'd0);
        check("mid_rst_enable", 0, 32'(d_en[0]), 32'd0);
        check("mid_rst_busy", 0, 32'(d_busy[0]), 32'd0);
        check("mid_rst_resp_valid", 0, 32'(d_resp_valid[0]), 32'd0);
        tick;
        at_neg;
        check("mid_rst_resp_valid2", 0, 32'(d_resp_valid[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 0, 32'(d_req_ready[0]), 32'd1);
        check("post_rst_busy", 0, 32'(d_busy[0]), 32'd0);
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
